// File: rtl/sprite_pkg.sv
// Shared defaults, config-field encodings and sequencer state encoding for the sprite motion block.
package sprite_pkg;

   localparam int unsigned COORD_W_DEF  = 16;
   localparam int unsigned SCREEN_W_DEF = 800;
   localparam int unsigned SCREEN_H_DEF = 600;
   localparam int unsigned IDX_W        = 3;

   typedef enum logic [1:0] {
      SEL_X_POS = 2'd0,
      SEL_Y_POS = 2'd1,
      SEL_X_VEL = 2'd2,
      SEL_Y_VEL = 2'd3
   } cfg_sel_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WRITE = 2'd2
   } state_e;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position step with reflection at 0 and at BOUND-1 (purely combinational).
module sprite_axis_step
   import sprite_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned BOUND   = SCREEN_W_DEF
) (
   input  logic signed [COORD_W-1:0] pos,
   input  logic signed [COORD_W-1:0] vel,
   output logic signed [COORD_W-1:0] new_pos_c,
   output logic signed [COORD_W-1:0] new_vel_c
);

   localparam logic signed [COORD_W:0]   BOUND_S = (COORD_W+1)'(BOUND);
   localparam logic signed [COORD_W-1:0] MAX_POS = COORD_W'(BOUND - 1);

   logic signed [COORD_W:0] next;

   // One extra bit keeps the sum from wrapping before the bound compare.
   always_comb begin
      next      = (COORD_W+1)'(pos) + (COORD_W+1)'(vel);
      new_pos_c = next[COORD_W-1:0];
      new_vel_c = vel;
      if (next >= BOUND_S) begin
         new_pos_c = MAX_POS;
         new_vel_c = -vel;
      end else if (next[COORD_W]) begin
         new_pos_c = '0;
         new_vel_c = -vel;
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-vsync sprite position sequencer: fetches each sprite, steps x/y, writes back, with a config write port.
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_SPRITES = 4,
   parameter int unsigned COORD_W     = COORD_W_DEF,
   parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H    = SCREEN_H_DEF
) (
   input  logic                             i_pix_clk,
   input  logic                             i_reset,
   input  logic                             i_vert_sync,
   input  logic [NUM_SPRITES-1:0]           i_sprite_en,
   input  logic                             i_cfg_we,
   input  logic [2:0]                       i_cfg_idx,
   input  logic [1:0]                       i_cfg_sel,
   input  logic signed [COORD_W-1:0]        i_cfg_data,
   output logic                             o_cfg_ready,
   output logic [NUM_SPRITES*COORD_W-1:0]   o_x_coord,
   output logic [NUM_SPRITES*COORD_W-1:0]   o_y_coord,
   output logic                             o_busy,
   output logic                             o_frame_done,
   output logic                             o_missed_frame,
   output logic [7:0]                       o_frame_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

   state_e                     state, state_next;
   logic [IDX_W-1:0]           idx;
   logic                       sync_q;
   logic                       vs_edge_c, fetch_c, commit_c, done_c, cfg_wr_c;

   logic signed [COORD_W-1:0]  pos_x [NUM_SPRITES];
   logic signed [COORD_W-1:0]  pos_y [NUM_SPRITES];
   logic signed [COORD_W-1:0]  vel_x [NUM_SPRITES];
   logic signed [COORD_W-1:0]  vel_y [NUM_SPRITES];

   logic signed [COORD_W-1:0]  sel_px, sel_py, sel_vx, sel_vy;
   logic                       sel_en;
   logic signed [COORD_W-1:0]  cur_px, cur_py, cur_vx, cur_vy;
   logic                       cur_en;
   logic signed [COORD_W-1:0]  nx_px, nx_py, nx_vx, nx_vy;

   assign vs_edge_c = i_vert_sync & ~sync_q;
   assign cfg_wr_c  = i_cfg_we & o_cfg_ready & (32'(i_cfg_idx) < NUM_SPRITES);

   always_ff @(posedge i_pix_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      fetch_c    = 1'b0;
      commit_c   = 1'b0;
      done_c     = 1'b0;
      case (state)
         S_IDLE:  if (vs_edge_c) state_next = S_FETCH;
         S_FETCH: begin
            fetch_c    = 1'b1;
            state_next = S_WRITE;
         end
         S_WRITE: begin
            commit_c = 1'b1;
            if (idx == LAST_IDX) begin
               state_next = S_IDLE;
               done_c     = 1'b1;
            end else begin
               state_next = S_FETCH;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Sync history resets high so a sync already high at reset release is not an edge.
   always_ff @(posedge i_pix_clk) begin
      if (i_reset) begin
         sync_q         <= 1'b1;
         idx            <= '0;
         o_busy         <= 1'b0;
         o_cfg_ready    <= 1'b1;
         o_frame_done   <= 1'b0;
         o_missed_frame <= 1'b0;
         o_frame_count  <= '0;
      end else begin
         sync_q         <= i_vert_sync;
         o_busy         <= (state_next != S_IDLE);
         o_cfg_ready    <= (state_next == S_IDLE);
         o_frame_done   <= done_c;
         o_missed_frame <= vs_edge_c & o_busy;
         if (done_c) begin
            idx           <= '0;
            o_frame_count <= o_frame_count + 8'd1;
         end else if (commit_c) begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   always_comb begin
      sel_px = '0;
      sel_py = '0;
      sel_vx = '0;
      sel_vy = '0;
      sel_en = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_px = pos_x[i];
            sel_py = pos_y[i];
            sel_vx = vel_x[i];
            sel_vy = vel_y[i];
            sel_en = i_sprite_en[i];
         end
      end
   end

   sprite_axis_step #(.COORD_W(COORD_W), .BOUND(SCREEN_W)) u_step_x (
      .pos       (cur_px),
      .vel       (cur_vx),
      .new_pos_c (nx_px),
      .new_vel_c (nx_vx)
   );

   sprite_axis_step #(.COORD_W(COORD_W), .BOUND(SCREEN_H)) u_step_y (
      .pos       (cur_py),
      .vel       (cur_vy),
      .new_pos_c (nx_py),
      .new_vel_c (nx_vy)
   );

   // Config writes only happen while idle, so they never collide with a sequence commit.
   always_ff @(posedge i_pix_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[i] <= '0;
            pos_y[i] <= '0;
            vel_x[i] <= '0;
            vel_y[i] <= '0;
         end
         cur_px <= '0;
         cur_py <= '0;
         cur_vx <= '0;
         cur_vy <= '0;
         cur_en <= 1'b0;
      end else begin
         if (fetch_c) begin
            cur_px <= sel_px;
            cur_py <= sel_py;
            cur_vx <= sel_vx;
            cur_vy <= sel_vy;
            cur_en <= sel_en;
         end
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (cfg_wr_c && i_cfg_idx == IDX_W'(i)) begin
               case (cfg_sel_e'(i_cfg_sel))
                  SEL_X_POS: pos_x[i] <= i_cfg_data;
                  SEL_Y_POS: pos_y[i] <= i_cfg_data;
                  SEL_X_VEL: vel_x[i] <= i_cfg_data;
                  SEL_Y_VEL: vel_y[i] <= i_cfg_data;
               endcase
            end
            if (commit_c && cur_en && idx == IDX_W'(i)) begin
               pos_x[i] <= nx_px;
               pos_y[i] <= nx_py;
               vel_x[i] <= nx_vx;
               vel_y[i] <= nx_vy;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
      assign o_x_coord[g*COORD_W +: COORD_W] = pos_x[g];
      assign o_y_coord[g*COORD_W +: COORD_W] = pos_y[g];
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with hand-computed expected positions and counters.
module tb_sprite_motion_ctrl;
   import sprite_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            vs;
   logic [N-1:0]    en;
   logic            we;
   logic [2:0]      cidx;
   logic [1:0]      csel;
   logic [CW-1:0]   cdata;
   logic            ready;
   logic [N*CW-1:0] x_coord;
   logic [N*CW-1:0] y_coord;
   logic            busy;
   logic            done;
   logic            missed;
   logic [7:0]      fcount;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sprite_motion_ctrl #(.NUM_SPRITES(N)) dut (
      .i_pix_clk      (clk),
      .i_reset        (rst),
      .i_vert_sync    (vs),
      .i_sprite_en    (en),
      .i_cfg_we       (we),
      .i_cfg_idx      (cidx),
      .i_cfg_sel      (csel),
      .i_cfg_data     (cdata),
      .o_cfg_ready    (ready),
      .o_x_coord      (x_coord),
      .o_y_coord      (y_coord),
      .o_busy         (busy),
      .o_frame_done   (done),
      .o_missed_frame (missed),
      .o_frame_count  (fcount)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; returns just after a negedge with we dropped.
   task automatic cfg_write(input logic [2:0] i, input logic [1:0] s, input logic [CW-1:0] d);
      int guard;
      we = 1'b1; cidx = i; csel = s; cdata = d;
      guard = 0;
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("cfg_ready_timeout", 0, 1);
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic pulse_sync();
      vs = 1'b1;
      @(negedge clk);
      vs = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_frame(output int n);
      pulse_sync();
      wait_idle(n);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nmiss;
      rst = 1'b1; vs = 1'b0; en = '0; we = 1'b0; cidx = '0; csel = '0; cdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 1);
      check("rst_count", fcount, 0);
      check("rst_x", x_coord, 0);
      rst = 1'b0;
      @(negedge clk);

      // basic move of sprite 0
      en = 4'hF;
      cfg_write(3'd0, SEL_X_POS, 16'd100);
      cfg_write(3'd0, SEL_Y_POS, 16'd50);
      cfg_write(3'd0, SEL_X_VEL, 16'd5);
      cfg_write(3'd0, SEL_Y_VEL, 16'd6);
      run_frame(n);
      check("t1_busy_cycles", n, 8);
      check("t1_done_pulse", done, 1);
      check("t1_x0", x_coord[15:0], 105);
      check("t1_y0", y_coord[15:0], 56);
      check("t1_count", fcount, 1);
      @(negedge clk);
      check("t1_done_drop", done, 0);

      // bounce at right edge and at top
      cfg_write(3'd1, SEL_X_POS, 16'd797);
      cfg_write(3'd1, SEL_Y_POS, 16'd3);
      cfg_write(3'd1, SEL_X_VEL, 16'd5);
      cfg_write(3'd1, SEL_Y_VEL, 16'hFFFA);
      run_frame(n);
      check("t2_x1_clamp", x_coord[31:16], 799);
      check("t2_y1_clamp", y_coord[31:16], 0);
      run_frame(n);
      check("t2_x1_reflect", x_coord[31:16], 794);
      check("t2_y1_reflect", y_coord[31:16], 6);
      check("t2_x0", x_coord[15:0], 115);

      // write held during busy
      pulse_sync();
      we = 1'b1; cidx = 3'd2; csel = SEL_X_POS; cdata = 16'd300;
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t3_hold_cycles", n, 8);
      check("t3_ready_at_done", done, 1);
      check("t3_x2_not_yet", x_coord[47:32], 0);
      @(negedge clk);
      we = 1'b0;
      check("t3_x2_applied", x_coord[47:32], 300);

      // write and edge in the same cycle
      vs = 1'b1; we = 1'b1; cidx = 3'd2; csel = SEL_X_VEL; cdata = 16'd7;
      @(negedge clk);
      vs = 1'b0; we = 1'b0;
      check("t3_busy_started", busy, 1);
      wait_idle(n);
      check("t3_same_cycle_busy", n, 8);
      check("t3_x2_new_vel", x_coord[47:32], 307);

      // second edge during a sequence
      pulse_sync();
      n = 0; nmiss = 0;
      while (busy && n < 100) begin
         n++;
         vs = (n == 3);
         if (missed) nmiss++;
         @(negedge clk);
      end
      vs = 1'b0;
      check("t4_busy_cycles", n, 8);
      check("t4_missed_pulses", nmiss, 1);
      check("t4_count", fcount, 6);
      @(negedge clk);
      check("t4_no_restart", busy, 0);

      // reset in the middle of a sequence, sync held high across release
      pulse_sync();
      repeat (3) @(negedge clk);
      rst = 1'b1; vs = 1'b1;
      @(negedge clk);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_missed", missed, 0);
      check("t6_count", fcount, 0);
      check("t6_x", x_coord, 0);
      check("t6_y", y_coord, 0);
      check("t6_ready", ready, 1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_sync_high_no_start", busy, 0);
      check("t6_no_partial", x_coord, 0);
      vs = 1'b0;
      @(negedge clk);

      // per-sprite enable and out-of-range index
      en = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         cfg_write(3'(k), SEL_X_POS, 16'(100 + 10 * k));
         cfg_write(3'(k), SEL_Y_POS, 16'd20);
         cfg_write(3'(k), SEL_X_VEL, 16'(k + 1));
         cfg_write(3'(k), SEL_Y_VEL, 16'd2);
      end
      cfg_write(3'd5, SEL_X_POS, 16'd999);
      check("t5_idx5_ignored", x_coord, {16'd130, 16'd120, 16'd110, 16'd100});
      run_frame(n);
      check("t5_x_enable", x_coord, {16'd130, 16'd123, 16'd110, 16'd101});
      check("t5_y_enable", y_coord, {16'd20, 16'd22, 16'd20, 16'd22});
      check("t5_count", fcount, 1);

      // frame counter wrap
      en = '0;
      repeat (254) run_frame(n);
      check("t7_count_255", fcount, 255);
      run_frame(n);
      check("t7_count_wrap", fcount, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
